// File: rtl/spi_fpga_master_cpha_eq_1_cpol_eq_0.sv
// SPI master, CPOL=0 / CPHA=1, MSB first, one full-duplex word per CS-low window.
// SCLK is derived from IN_CLK: every SCLK half-period lasts CLK_DIV system clocks.
module spi_fpga_master_cpha_eq_1_cpol_eq_0 #(
    parameter int PACK_LENGTH       = 8,
    parameter int PACK_LENGTH_LOG_2 = $clog2(PACK_LENGTH),
    parameter int CLK_DIV           = 2
) (
    input  logic                   IN_CLK,
    input  logic                   IN_RESET_N,
    input  logic                   IN_START,
    input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
    output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
    output logic                   OUT_BUSY,
    output logic                   OUT_DONE,
    output logic                   CS,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic                   MISO
);
    localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BCW = PACK_LENGTH_LOG_2 + 1;
    localparam logic [HCW-1:0] H_LAST = HCW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] N_LAST = BCW'(PACK_LENGTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} state_t;

    state_t                 state_q, state_d;
    logic [HCW-1:0]         hcnt_q, hcnt_d;
    logic [BCW-1:0]         bcnt_q, bcnt_d;
    logic [PACK_LENGTH-1:0] tx_q, tx_d;
    logic [PACK_LENGTH-1:0] rx_q, rx_d;
    logic [PACK_LENGTH-1:0] rdata_q, rdata_d;
    logic                   cs_q, cs_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   half_end;

    assign half_end = (hcnt_q == H_LAST);

    always_ff @(posedge IN_CLK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = (state_q == IDLE || half_end) ? '0 : hcnt_q + HCW'(1);
        bcnt_d  = bcnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (IN_START) begin
                    tx_d    = IN_TRANSMIT_DATA;
                    rx_d    = '0;
                    bcnt_d  = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (half_end) begin
                    sclk_d  = 1'b1;
                    mosi_d  = tx_q[PACK_LENGTH-1];
                    tx_d    = {tx_q[PACK_LENGTH-2:0], 1'b0};
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                // Falling edge captures MISO; rising edge launches the next MOSI bit.
                if (half_end) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        rx_d   = {rx_q[PACK_LENGTH-2:0], MISO};
                        bcnt_d = bcnt_q + BCW'(1);
                        if (bcnt_q == N_LAST) state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        mosi_d = tx_q[PACK_LENGTH-1];
                        tx_d   = {tx_q[PACK_LENGTH-2:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                if (half_end) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    rdata_d = rx_q;
                    done_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (half_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign OUT_RECEIVE_DATA = rdata_q;
    assign OUT_BUSY         = busy_q;
    assign OUT_DONE         = done_q;
    assign CS               = cs_q;
    assign SCLK             = sclk_q;
    assign MOSI             = mosi_q;
endmodule

// File: tb/tb_spi_fpga_master_cpha_eq_1_cpol_eq_0.sv
// Randomized bench for the CPHA=1/CPOL=0 SPI master: a timing/data reference model feeds a
// scoreboard queue, a separate monitor checks waveform windows and completed words.
module tb_spi_fpga_master_cpha_eq_1_cpol_eq_0;
    localparam int N         = 8;
    localparam int H         = 2;
    localparam int N2        = 16;
    localparam int SPAN_DONE = (2 * N + 1) * H;
    localparam int SPAN_BUSY = (2 * N + 2) * H;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         a_start = 1'b0;
    logic [N-1:0] a_tx = '0;
    logic [N-1:0] a_rdata;
    logic         a_busy, a_done, a_cs, a_sclk, a_mosi, a_miso;

    logic          b_start = 1'b0;
    logic [N2-1:0] b_tx = '0;
    logic [N2-1:0] b_rdata;
    logic          b_busy, b_done, b_cs, b_sclk, b_mosi;
    logic          b_miso = 1'b1;

    logic         loop_mode = 1'b0;
    logic [N-1:0] slv_word = '0;
    logic [N-1:0] slv_sh = '0;
    logic         slv_miso = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [N-1:0] tx;
        logic [N-1:0] rx;
        int           done_edge;
    } exp_t;
    exp_t exp_q[$];

    int           cur_t0 = -100000;
    int           free_edge = 0;
    int           accept_cnt = 0;
    logic [N-1:0] exp_rdata = '0;
    logic [N-1:0] mosi_word = '0;
    int           viol = 0;
    int           rises = 0, falls = 0;
    logic         prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

    spi_fpga_master_cpha_eq_1_cpol_eq_0 #(.PACK_LENGTH(N), .CLK_DIV(H)) dut_a (
        .IN_CLK(clk), .IN_RESET_N(rst_n), .IN_START(a_start), .IN_TRANSMIT_DATA(a_tx),
        .OUT_RECEIVE_DATA(a_rdata), .OUT_BUSY(a_busy), .OUT_DONE(a_done),
        .CS(a_cs), .SCLK(a_sclk), .MOSI(a_mosi), .MISO(a_miso));

    spi_fpga_master_cpha_eq_1_cpol_eq_0 #(.PACK_LENGTH(N2), .CLK_DIV(1)) dut_b (
        .IN_CLK(clk), .IN_RESET_N(rst_n), .IN_START(b_start), .IN_TRANSMIT_DATA(b_tx),
        .OUT_RECEIVE_DATA(b_rdata), .OUT_BUSY(b_busy), .OUT_DONE(b_done),
        .CS(b_cs), .SCLK(b_sclk), .MOSI(b_mosi), .MISO(b_miso));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: loads its word when selected, shifts out MSB first on each SCLK rise.
    always @(negedge a_cs or posedge a_sclk) begin
        if (a_sclk) begin
            slv_miso <= slv_sh[N-1];
            slv_sh   <= slv_sh << 1;
        end else begin
            slv_sh <= slv_word;
        end
    end
    assign a_miso = loop_mode ? a_mosi : slv_miso;

    // Reference model: decides acceptance from start timing alone and predicts the word.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            cur_t0    = -100000;
            free_edge = 0;
        end else if (a_start && (cyc + 1 >= free_edge)) begin
            cur_t0      = cyc + 1;
            free_edge   = cur_t0 + SPAN_BUSY + 1;
            e.tx        = a_tx;
            e.rx        = loop_mode ? a_tx : slv_word;
            e.done_edge = cur_t0 + SPAN_DONE;
            exp_q.push_back(e);
            accept_cnt++;
        end
    end

    // Monitor
    always @(negedge clk) begin
        int   d0, ds;
        logic eb, ec, es;
        exp_t e;
        if (!rst_n) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
            rises     = 0;
            falls     = 0;
            exp_rdata = '0;
        end else begin
            d0 = cyc - cur_t0;
            ds = d0 - H;
            eb = (d0 >= 0) && (d0 < SPAN_BUSY);
            ec = !((d0 >= 0) && (d0 < SPAN_DONE));
            es = (ds >= 0) && (ds < 2 * N * H) && (((ds / H) % 2) == 0);
            chk("busy", a_busy, eb);
            chk("cs", a_cs, ec);
            chk("sclk", a_sclk, es);
            if (a_done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_edge);
                    chk("rx_word", a_rdata, e.rx);
                    chk("mosi_word", mosi_word, e.tx);
                    exp_rdata = e.rx;
                end
            end else begin
                chk("rdata_hold", a_rdata, exp_rdata);
            end
            if (a_cs && a_sclk) viol++;
            if (!a_cs && prev_cs) begin
                rises = 0;
                falls = 0;
            end
            if (a_sclk && !prev_sclk) begin
                rises++;
                mosi_word = {mosi_word[N-2:0], a_mosi};
            end
            if (!a_sclk && prev_sclk) begin
                falls++;
                if (a_mosi != prev_mosi) viol++;
            end
            if (a_cs && !prev_cs) begin
                chk("rise_count", rises, N);
                chk("fall_count", falls, N);
            end
            prev_cs   = a_cs;
            prev_sclk = a_sclk;
            prev_mosi = a_mosi;
        end
    end

    task automatic pulse_start(input logic [N-1:0] tx);
        a_tx    = tx;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if ((cyc + 1 >= free_edge) && (exp_q.size() == 0)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", ok, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            n0, t0b, dsb, b_rises;
        logic          got_done, bprev, esb;
        logic [N2-1:0] b_word;
        bit            ok;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", a_cs, 1);
        chk("rst_sclk", a_sclk, 0);
        chk("rst_mosi", a_mosi, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_rdata", a_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort a transfer with an asynchronous reset mid-word.
        slv_word = 8'h96;
        pulse_start(8'hC3);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_cs", a_cs, 1);
        chk("abort_sclk", a_sclk, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_rdata", a_rdata, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        slv_word = 8'h3C;
        pulse_start(8'hA5);
        wait_idle();

        // Start request in the middle of a transfer must be ignored.
        slv_word = 8'h69;
        pulse_start(8'hA5);
        repeat (9) @(negedge clk);
        pulse_start(8'hFF);
        wait_idle();

        // Loopback with start held high: two back-to-back words.
        loop_mode = 1'b1;
        n0 = accept_cnt;
        a_tx = 8'h81;
        a_start = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (accept_cnt == n0 + 1) begin ok = 1'b1; break; end
        end
        chk("accept1_timeout", ok, 1);
        a_tx = 8'h7E;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (accept_cnt == n0 + 2) begin ok = 1'b1; break; end
        end
        chk("accept2_timeout", ok, 1);
        a_start = 1'b0;
        wait_idle();
        loop_mode = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wait_idle();
            loop_mode = 1'($urandom % 2);
            slv_word  = N'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_start(N'($urandom));
            if (($urandom % 2) == 1) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
                pulse_start(N'($urandom));
            end
        end
        wait_idle();
        loop_mode = 1'b0;

        // CLK_DIV=1, 16-bit word, MISO held high.
        @(negedge clk);
        b_tx    = 16'h8001;
        b_start = 1'b1;
        t0b     = cyc + 1;
        @(negedge clk);
        b_start  = 1'b0;
        b_rises  = 0;
        b_word   = '0;
        got_done = 1'b0;
        bprev    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            dsb = cyc - t0b - 1;
            esb = (dsb >= 0) && (dsb < 2 * N2) && ((dsb % 2) == 0);
            chk("b_sclk", b_sclk, esb);
            if (b_sclk && !bprev) begin
                b_rises++;
                b_word = {b_word[N2-2:0], b_mosi};
            end
            if (b_done) begin
                got_done = 1'b1;
                chk("b_done_cycle", cyc, t0b + 33);
                chk("b_rx", b_rdata, 16'hFFFF);
            end
            bprev = b_sclk;
            @(negedge clk);
        end
        chk("b_done_seen", got_done, 1);
        chk("b_rises", b_rises, N2);
        chk("b_mosi_word", b_word, 16'h8001);
        chk("b_busy_end", b_busy, 0);
        chk("b_cs_end", b_cs, 1);

        chk("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
